fb_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single-port framebuffer SRAM among the 2D GPU's requesters: display refresh, rasterizer and host write port. It sits between the requester datapaths and the SRAM interface. It grants one requester at a time for a burst of up to MAX_BURST beats and forwards that requester's beats to the memory. It returns read data tagged with the owner's index.

---
 rtl/fb_arb_pkg.sv | 22 ++
 rtl/rr_picker.sv | 37 +++
 rtl/fb_arbiter.sv | 141 ++++++++++++++
 tb/tb_fb_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_arb_pkg.sv
// ============================================================================
// Module      : fb_arb_pkg
// Description : Shared types and default sizes for the framebuffer arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fb_arb_pkg;

    localparam int c_NUM_REQ   = 3;
    localparam int c_ADDR_W    = 16;
    localparam int c_DATA_W    = 16;
    localparam int c_MAX_BURST = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin priority encoder; search starts at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker
    import fb_arb_pkg::*;
#(
    parameter int NUM_REQ = c_NUM_REQ,
    parameter int PTR_W   = $clog2(c_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    int w_idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        w_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(ptr) + k) % NUM_REQ;
            if (!valid && req[w_idx[PTR_W-1:0]]) begin
                winner[w_idx[PTR_W-1:0]] = 1'b1;
                valid                    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fb_arbiter.sv
// ============================================================================
// Module      : fb_arbiter
// Description : Round-robin burst arbiter sharing the framebuffer SRAM.
//               Optional macro FB_ARBITER_DISPLAY_PRIO_EN gives requester 0
//               absolute priority at each arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_arbiter
    import fb_arb_pkg::*;
#(
    parameter int NUM_REQ   = c_NUM_REQ,
    parameter int ADDR_W    = c_ADDR_W,
    parameter int DATA_W    = c_DATA_W,
    parameter int MAX_BURST = c_MAX_BURST
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         last,
    input  logic [NUM_REQ-1:0]         wr,
    input  logic [NUM_REQ*ADDR_W-1:0]  addr,
    input  logic [NUM_REQ*DATA_W-1:0]  wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [DATA_W-1:0]          rdata,
    output logic                       rvalid,
    output logic [$clog2(NUM_REQ)-1:0] rid,
    output logic                       mem_en,
    output logic                       mem_wr,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata
);

    localparam int c_PTR_W = $clog2(NUM_REQ);
    localparam int c_CNT_W = $clog2(MAX_BURST) + 1;

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_PTR_W-1:0]   r_owner;
    logic [c_PTR_W-1:0]   r_rid;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_rvalid;

    logic [NUM_REQ-1:0]   w_rr_winner;
    logic                 w_rr_valid;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic [c_PTR_W-1:0]   w_win_idx;
    logic [c_PTR_W-1:0]   w_ptr_next;
    logic [c_CNT_W-1:0]   w_cnt_inc;
    logic                 w_beat;
    logic                 w_rd_beat;
    logic                 w_burst_end;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_PTR_W)
    ) u_rr_picker (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_rr_winner),
        .valid  (w_rr_valid)
    );

    always_comb begin
        w_win_oh = w_rr_winner;
`ifdef FB_ARBITER_DISPLAY_PRIO_EN
        if (req[0]) begin
            w_win_oh = {{(NUM_REQ-1){1'b0}}, 1'b1};
        end
`endif
        w_win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_oh[i]) begin
                w_win_idx = c_PTR_W'(i);
            end
        end
        w_ptr_next = (w_win_idx == c_PTR_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
    end

    // Only the owner's lanes matter; every other requester is ignored.
    assign w_beat      = (r_state == BURST) && req[r_owner];
    assign w_rd_beat   = w_beat && !wr[r_owner];
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_burst_end = !req[r_owner] || last[r_owner] ||
                         (w_cnt_inc == c_CNT_W'(MAX_BURST));

    assign mem_en    = w_beat;
    assign mem_wr    = w_beat && wr[r_owner];
    assign mem_addr  = w_beat ? addr[r_owner*ADDR_W +: ADDR_W]  : '0;
    assign mem_wdata = w_beat ? wdata[r_owner*DATA_W +: DATA_W] : '0;

    assign gnt    = r_gnt;
    assign rvalid = r_rvalid;
    assign rid    = r_rid;
    // SRAM data is valid exactly in the rvalid cycle, so pass it straight through.
    assign rdata  = r_rvalid ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_cnt    <= '0;
            r_rvalid <= 1'b0;
            r_rid    <= '0;
        end else begin
            r_rvalid <= w_rd_beat;
            if (w_rd_beat) begin
                r_rid <= r_owner;
            end
            case (r_state)
                IDLE: begin
                    if (w_rr_valid) begin
                        r_gnt   <= w_win_oh;
                        r_owner <= w_win_idx;
                        r_ptr   <= w_ptr_next;
                        r_cnt   <= '0;
                        r_state <= BURST;
                    end
                end
                BURST: begin
                    if (w_beat) begin
                        r_cnt <= w_cnt_inc;
                    end
                    if (w_burst_end) begin
                        r_gnt   <= '0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fb_arbiter.sv
// ============================================================================
// Module      : tb_fb_arbiter
// Description : Self-checking bench for fb_arbiter (vector table, directed
//               corner sequences, randomized traffic against a rule model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fb_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MB = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, last, wr;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt;
    logic [DW-1:0]   rdata;
    logic            rvalid;
    logic [1:0]      rid;
    logic            mem_en, mem_wr;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata = '0;

    always #5 clk = ~clk;

    fb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .last(last), .wr(wr), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .rid(rid),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // SRAM stand-in: read data is a fixed function of the address.
    always @(posedge clk) begin
        if (mem_en && !mem_wr) mem_rdata <= mem_addr ^ 16'hA5A5;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: rule-level view of who owns the memory.
    bit          m_busy = 0;
    int          m_owner = 0, m_cnt = 0, m_ptr = 0, m_rid = 0;
    bit          m_rv = 0;
    logic [15:0] m_raddr = '0;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic model_check();
        logic [N-1:0] eg;
        bit beat;
        eg = '0;
        if (m_busy) eg[m_owner] = 1'b1;
        beat = m_busy && req[m_owner];
        chk("m_gnt", gnt, eg);
        chk("m_mem_en", mem_en, beat);
        if (beat) begin
            chk("m_mem_wr", mem_wr, wr[m_owner]);
            chk("m_mem_addr", mem_addr, addr[m_owner*AW +: AW]);
            chk("m_mem_wdata", mem_wdata, wdata[m_owner*DW +: DW]);
        end
        chk("m_rvalid", rvalid, m_rv);
        if (m_rv) begin
            chk("m_rid", rid, m_rid);
            chk("m_rdata", rdata, m_raddr ^ 16'hA5A5);
        end
    endtask

    task automatic model_step();
        bit beat;
        int w;
        beat = m_busy && req[m_owner];
        if (rst) begin
            m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_rv = 0; m_rid = 0;
        end else begin
            m_rv = beat && !wr[m_owner];
            if (m_rv) begin
                m_rid   = m_owner;
                m_raddr = addr[m_owner*AW +: AW];
            end
            if (!m_busy) begin
                if (req != '0) begin
`ifdef FB_ARBITER_DISPLAY_PRIO_EN
                    if (req[0]) w = 0;
                    else        w = rr_pick(req, m_ptr);
`else
                    w = rr_pick(req, m_ptr);
`endif
                    m_busy = 1; m_owner = w; m_cnt = 0; m_ptr = (w + 1) % N;
                end
            end else if (!beat) begin
                m_busy = 0;
            end else begin
                m_cnt++;
                if (last[m_owner] || m_cnt == MB) m_busy = 0;
            end
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic advance();
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        at_neg();
        advance();
    endtask

    task automatic idle_inputs();
        req = '0; last = '0; wr = '0; addr = '0; wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        cyc();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  last;
        logic [15:0] a1;
        logic [2:0]  e_gnt;
        logic        e_en;
        logic [15:0] e_addr;
        logic        e_rv;
        logic [1:0]  e_rid;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t       tbl[6];
    logic [2:0] exp_rr[4];
    int         n_en;

    initial begin
        tbl[0] = '{3'b010, 3'b000, 16'h0010, 3'b000, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000};
        tbl[1] = '{3'b010, 3'b000, 16'h0010, 3'b010, 1'b1, 16'h0010, 1'b0, 2'd0, 16'h0000};
        tbl[2] = '{3'b010, 3'b000, 16'h0011, 3'b010, 1'b1, 16'h0011, 1'b1, 2'd1, 16'hA5B5};
        tbl[3] = '{3'b010, 3'b010, 16'h0012, 3'b010, 1'b1, 16'h0012, 1'b1, 2'd1, 16'hA5B4};
        tbl[4] = '{3'b000, 3'b000, 16'h0000, 3'b000, 1'b0, 16'h0000, 1'b1, 2'd1, 16'hA5B7};
        tbl[5] = '{3'b000, 3'b000, 16'h0000, 3'b000, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000};
`ifdef FB_ARBITER_DISPLAY_PRIO_EN
        exp_rr = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
        exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif

        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        at_neg();
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rid", rid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        advance();
        rst = 1'b0;

        // Single requester, three reads.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req = tbl[i].req; last = tbl[i].last; wr = '0; wdata = '0;
            addr = {16'h0000, tbl[i].a1, 16'h0000};
            at_neg();
            chk("tbl_gnt", gnt, tbl[i].e_gnt);
            chk("tbl_mem_en", mem_en, tbl[i].e_en);
            if (tbl[i].e_en) chk("tbl_mem_addr", mem_addr, tbl[i].e_addr);
            chk("tbl_rvalid", rvalid, tbl[i].e_rv);
            if (tbl[i].e_rv) begin
                chk("tbl_rid", rid, tbl[i].e_rid);
                chk("tbl_rdata", rdata, tbl[i].e_rdata);
            end
            advance();
        end

        // All requesting, one-beat bursts.
        do_reset();
        req = 3'b111; last = 3'b111; wr = '0;
        addr = {16'h0300, 16'h0200, 16'h0100};
        for (int c = 0; c < 8; c++) begin
            at_neg();
            if (c % 2 == 1) chk("rr_gnt", gnt, exp_rr[c / 2]);
            else            chk("rr_bubble", gnt, 0);
            advance();
        end

        // Burst cap: requester 2 writes ten beats, last only on the tenth.
        do_reset();
        n_en = 0;
        for (int c = 0; c < 13; c++) begin
            req  = (c == 12) ? 3'b000 : 3'b100;
            wr   = 3'b100;
            last = (c == 11) ? 3'b100 : 3'b000;
            addr = {16'(16'h0400 + c), 32'h0};
            wdata = {16'(16'h1000 + c), 32'h0};
            at_neg();
            if (c >= 1 && c <= 8 && mem_en) n_en++;
            if (c == 8)  chk("cap_gnt_beat8", gnt, 3'b100);
            if (c == 9) begin
                chk("cap_bubble_gnt", gnt, 0);
                chk("cap_bubble_en", mem_en, 0);
            end
            if (c == 10) begin
                chk("cap_regrant", gnt, 3'b100);
                chk("cap_beat9_en", mem_en, 1);
            end
            if (c == 12) chk("cap_end_gnt", gnt, 0);
            advance();
        end
        chk("cap_first_grant_beats", n_en, 8);

        // Abandon: owner 0 drops req after two beats.
        do_reset();
        n_en = 0;
        for (int c = 0; c < 5; c++) begin
            req = (c == 3 || c == 4) ? 3'b000 : 3'b001;
            wr = '0; last = '0;
            addr = {32'h0, 16'(16'h0500 + c)};
            at_neg();
            if (mem_en) n_en++;
            if (c == 3) begin
                chk("abn_gnt_held", gnt, 3'b001);
                chk("abn_no_beat", mem_en, 0);
            end
            if (c == 4) chk("abn_gnt_clr", gnt, 0);
            advance();
        end
        chk("abn_beats", n_en, 2);

        // Reset during beat 2 of a read burst.
        do_reset();
        req = 3'b010; wr = '0; last = '0; addr = {16'h0, 16'h0600, 16'h0};
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req = 3'b111; last = 3'b111;
        at_neg();
        chk("rstm_gnt", gnt, 0);
        chk("rstm_rvalid", rvalid, 0);
        chk("rstm_mem_en", mem_en, 0);
        advance();
        at_neg();
        chk("rstm_first_arb", gnt, 3'b001);
        advance();

        // Randomized traffic against the rule model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < N; i++) begin
                req[i]  = ($urandom_range(0, 3) != 0);
                last[i] = ($urandom_range(0, 3) == 0);
                wr[i]   = $urandom_range(0, 1) == 1;
            end
            addr  = 48'({$urandom(), $urandom()});
            wdata = 48'({$urandom(), $urandom()});
            cyc();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
